// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - opcodes and FSM encoding for the JK bank sequencer
package jk_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DN     = 3'b110;
    localparam logic [2:0] OP_SHIFT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_multi(input logic [2:0] op);
        return (op == OP_UP) || (op == OP_DN) || (op == OP_SHIFT);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop, async active-high reset to Q=0
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command FSM driving J/K vectors into a JK flip-flop bank
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             accept;

    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Toggle enables for counting: a bit flips when every lower bit is 1 (up) or 0 (down).
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_carry
            assign up_t[gi] = &q[gi-1:0];
            assign dn_t[gi] = &qbar[gi-1:0];
        end
        for (gi = 0; gi < WIDTH; gi++) begin : g_bank
            jk_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .j    (j[gi]),
                .k    (k[gi]),
                .q    (q[gi]),
                .qbar (qbar[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= OP_NOP;
            data_r <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                cnt    <= cmd_len;
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        j         = '0;
        k         = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (is_multi(cmd_op) && (cmd_len != '0)) ? RUN : EXEC;
            end
            EXEC: begin
                state_nxt = DONE;
                // Multi-step ops only land here with len=0, so they hold.
                case (op_r)
                    OP_CLEAR:  k = '1;
                    OP_SET:    j = '1;
                    OP_LOAD: begin
                        j = data_r;
                        k = ~data_r;
                    end
                    OP_TOGGLE: begin
                        j = data_r;
                        k = data_r;
                    end
                    default: ;
                endcase
            end
            RUN: begin
                if (cnt == LEN_W'(1))
                    state_nxt = DONE;
                case (op_r)
                    OP_UP: begin
                        j = up_t;
                        k = up_t;
                    end
                    OP_DN: begin
                        j = dn_t;
                        k = dn_t;
                    end
                    OP_SHIFT: begin
                        j = {q[WIDTH-2:0], data_r[0]};
                        k = {qbar[WIDTH-2:0], ~data_r[0]};
                    end
                    default: ;
                endcase
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_bank_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q         (q),
        .qbar      (qbar),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command at a negedge once idle; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Single-step style command: waits for done (bounded) and checks the final q.
    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] data,
                       input logic [7:0] len, input logic [7:0] exp_q);
        int n = 0;
        issue(op, data, len);
        @(negedge clk);
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
        @(negedge clk);
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_qbar", {24'd0, qbar}, 32'hFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;

        // LOAD latency: EXEC, then q and done after T1, ready after T2
        issue(3'b011, 8'hA5, 8'd0);
        @(negedge clk);
        check("ld_exec_q", {24'd0, q}, 32'h00);
        check("ld_exec_ready", {31'd0, cmd_ready}, 32'd0);
        check("ld_exec_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("ld_q", {24'd0, q}, 32'hA5);
        check("ld_qbar", {24'd0, qbar}, 32'h5A);
        check("ld_done", {31'd0, done}, 32'd1);
        check("ld_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ld_done_clr", {31'd0, done}, 32'd0);
        check("ld_ready_back", {31'd0, cmd_ready}, 32'd1);

        run("tog", 3'b100, 8'h0F, 8'd0, 8'hAA);
        run("clr", 3'b001, 8'h00, 8'd0, 8'h00);
        run("set", 3'b010, 8'h00, 8'd0, 8'hFF);
        run("nop", 3'b000, 8'h12, 8'd0, 8'hFF);

        // COUNT_UP len=3 from 0xFE wraps through 0x00
        run("ld_fe", 3'b011, 8'hFE, 8'd0, 8'hFE);
        issue(3'b101, 8'h00, 8'd3);
        @(negedge clk);
        check("up_run_q", {24'd0, q}, 32'hFE);
        check("up_run_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("up_s1", {24'd0, q}, 32'hFF);
        check("up_s1_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("up_s2", {24'd0, q}, 32'h00);
        check("up_s2_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("up_s3", {24'd0, q}, 32'h01);
        check("up_s3_done", {31'd0, done}, 32'd1);
        check("up_s3_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("up_end_done", {31'd0, done}, 32'd0);
        check("up_end_busy", {31'd0, busy}, 32'd0);
        check("up_end_q", {24'd0, q}, 32'h01);

        // COUNT_DN len=2 from 0x01 wraps to all ones
        run("ld_01", 3'b011, 8'h01, 8'd0, 8'h01);
        issue(3'b110, 8'h00, 8'd2);
        @(negedge clk);
        @(negedge clk);
        check("dn_s1", {24'd0, q}, 32'h00);
        @(negedge clk);
        check("dn_s2", {24'd0, q}, 32'hFF);
        check("dn_s2_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        run("up_len0", 3'b101, 8'h00, 8'd0, 8'hFF);

        // SHIFT len=2 serial-in 1, with a LOAD held on cmd_valid while busy
        run("ld_81", 3'b011, 8'h81, 8'd0, 8'h81);
        issue(3'b111, 8'h01, 8'd2);
        cmd_op    = 3'b011;
        cmd_data  = 8'h55;
        cmd_len   = 8'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("sh_run_q", {24'd0, q}, 32'h81);
        @(negedge clk);
        check("sh_s1", {24'd0, q}, 32'h03);
        @(negedge clk);
        check("sh_s2", {24'd0, q}, 32'h07);
        check("sh_s2_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("sh_idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("sh_idle_q", {24'd0, q}, 32'h07);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_exec_q", {24'd0, q}, 32'h07);
        check("held_exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("held_ld_q", {24'd0, q}, 32'h55);
        check("held_ld_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Async reset mid-RUN of COUNT_UP len=10
        run("ld_10", 3'b011, 8'h10, 8'd0, 8'h10);
        issue(3'b101, 8'h00, 8'd10);
        repeat (3) @(negedge clk);
        check("mid_q", {24'd0, q}, 32'h12);
        rst = 1'b1;
        #1;
        check("mid_rst_q", {24'd0, q}, 32'h00);
        check("mid_rst_qbar", {24'd0, qbar}, 32'hFF);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst", 3'b011, 8'h3C, 8'd0, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Command-driven controller for a bank of WIDTH JK flip-flops. It accepts one command at a time over a valid/ready handshake and drives per-bit J/K vectors to the bank. Supported operations are clear, set, load, toggle-mask, counting up or down by N steps, and shift-left by N steps. It sits between a host/register interface and the JK storage bank, so no other logic drives J/K directly.

Parameters:
WIDTH, 8, number of JK flip-flops in the bank (>=2)
LEN_W, 8, width of step-count field for multi-step ops

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  opcode (see Behaviour)
cmd_data  input  WIDTH  load value / toggle mask / serial-in (bit 0) for shift
cmd_len  input  LEN_W  step count for COUNT_UP, COUNT_DN, SHIFT
q  output  WIDTH  bank Q outputs
qbar  output  WIDTH  bank Qbar outputs, always ~q
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse, command complete

Behaviour:
- Reset (async, any time, including mid-command): q=0, qbar=all ones, state=IDLE, cmd_ready=1, busy=0, done=0. Any in-flight command is dropped.
- Clock is clk. Reset is rst, asynchronous, active-high.
- Bank bit semantics per cycle:
  - JK=00 holds.
  - JK=01 clears.
  - JK=10 sets.
  - JK=11 toggles.
  - q updates at the edge ending the cycle in which J/K are driven.
- FSM states: IDLE, EXEC, RUN, DONE. J=K=0 (hold) in IDLE and DONE.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, latch op/data/len.
  - Go to RUN if op is multi-step and len!=0. Otherwise go to EXEC.
- EXEC (1 cycle): drive the single-step JK vector, then go to DONE.
- RUN:
  - Each cycle applies one step and decrements the remaining count.
  - On the edge where the count is 1, the last step is applied and the state goes to DONE.
- DONE (1 cycle): done=1, q holds the final value, then go to IDLE. cmd_ready=0 in EXEC/RUN/DONE.
- Latency:
  - Single-step op accepted at edge T0: new q is visible after edge T1, done is high during T1..T2, cmd_ready is high after T2.
  - Multi-step with len=L: L RUN cycles, then DONE.
- Opcodes:
  - 000 NOP: J=K=0 via EXEC. done still pulses.
  - 001 CLEAR: J=0, K=1 for all bits.
  - 010 SET: J=1, K=0 for all bits.
  - 011 LOAD: J=data, K=~data.
  - 100 TOGGLE: J=K=data (mask). Bits with mask 0 hold.
  - 101 COUNT_UP: bit0 J=K=1. For bit i, J=K=AND(q[i-1:0]). Wraps modulo 2^WIDTH.
  - 110 COUNT_DN: bit0 J=K=1. For bit i, J=K=AND(qbar[i-1:0]). Wraps from 0 to all ones.
  - 111 SHIFT: bit0 J=data[0], K=~data[0]. For bit i, J=q[i-1], K=qbar[i-1]. Serial-in is constant for the whole command. The MSB is discarded.
- Multi-step op with len=0: takes the EXEC path with hold (no change), done pulses.
- cmd_valid while busy is ignored. Command fields are not required stable after acceptance.
- Counting and shifting use the live q each cycle. Intermediate values are visible on q.

Decomposition:
- Package jk_seq_pkg holds:
  - the opcode localparams (OP_NOP..OP_SHIFT)
  - the FSM state encoding (IDLE, EXEC, RUN, DONE, 2 bits)
- Sub-module jk_cell: one JK flip-flop with async active-high reset to Q=0/Qbar=1, instantiated WIDTH times via generate.
- The controller is the FSM, the remaining-step counter and the JK vector mux.

Test Plan:
- Assert rst mid-RUN of COUNT_UP len=10 -> q=0x00, qbar=0xFF, busy=0, done=0 immediately. The next command is accepted normally.
- LOAD data=0xA5 (WIDTH=8) -> q=0xA5, qbar=0x5A one edge after acceptance. done pulses 1 cycle. cmd_ready returns 2 edges after acceptance.
- From q=0xA5: TOGGLE mask=0x0F -> q=0xAA. Then CLEAR -> q=0x00. Then SET -> q=0xFF.
- LOAD 0xFE, then COUNT_UP len=3 -> q steps 0xFF, 0x00, 0x01 (wrap). busy stays high 3 RUN cycles plus DONE. done pulses once.
- LOAD 0x01, then COUNT_DN len=2 -> q=0x00, then 0xFF. COUNT_UP len=0 -> q unchanged, done pulses once.
- LOAD 0x81, SHIFT len=2 with data[0]=1 -> q=0x03, then 0x07. A second cmd_valid held during busy is not accepted until cmd_ready is high.
